// File: rtl/new_usb_descriptor_fetch_pkg.sv
// new_usb_descriptor_fetch_pkg
// Shared types and constants for the OHCI descriptor fetch stage.
//   fetch_type_e  : descriptor kind requested by the list service
//   fetch_state_e : fetch FSM state, also exported for observation
//   fetch_beats() : number of R beats needed for one descriptor
package new_usb_descriptor_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_ED   = 2'd0,
        FETCH_GTD  = 2'd1,
        FETCH_ITD  = 2'd2,
        FETCH_RSVD = 2'd3
    } fetch_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam int EdBytes  = 16;
    localparam int GtdBytes = 16;
    localparam int ItdBytes = 32;

    // Largest burst is an ITD on a 32-bit bus: 8 beats.
    localparam int BeatCntWidth = $clog2(8);

    localparam logic [1:0] AxiBurstIncr = 2'b01;
    localparam logic [1:0] AxiRespOkay  = 2'b00;

    // Beats per descriptor; data_width must be 32, 64 or 128.
    function automatic int fetch_beats(input fetch_type_e kind, input int data_width);
        int bytes;
        case (kind)
            FETCH_ITD: bytes = ItdBytes;
            FETCH_GTD: bytes = GtdBytes;
            default:   bytes = EdBytes;
        endcase
        return bytes / (data_width / 8);
    endfunction

endpackage

// File: rtl/new_usb_descriptor_fetch_if.sv
// new_usb_descriptor_fetch_if
// Bundles the fetch request, AXI AR/R and unpacker stream signals of the
// descriptor fetch stage.
//   fetch_* : request from the list service (valid/ready)
//   ar_*    : AXI read address channel (valid/ready)
//   r_*     : AXI read data channel (valid/ready)
//   dma_*   : descriptor beats to the unpacker (valid/ready)
//   unrec_error_o : one-cycle error pulse
//   fsm_state     : current FSM state, for observation only
// Handshake rule on every channel: a transfer happens on a rising clock
// edge where valid and ready are both high; once valid is raised the
// payload stays stable and valid stays high until that transfer.
// modport master is the fetch block, modport slave is its environment.
interface new_usb_descriptor_fetch_if
    import new_usb_descriptor_fetch_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 4
);
    logic                 fetch_valid_i;
    logic                 fetch_ready_o;
    logic [27:0]          fetch_addr_i;
    logic [1:0]           fetch_type_i;
    logic [AddrWidth-1:0] ar_addr_o;
    logic [7:0]           ar_len_o;
    logic [2:0]           ar_size_o;
    logic [1:0]           ar_burst_o;
    logic [IdWidth-1:0]   ar_id_o;
    logic                 ar_valid_o;
    logic                 ar_ready_i;
    logic [DataWidth-1:0] r_data_i;
    logic [1:0]           r_resp_i;
    logic                 r_last_i;
    logic                 r_valid_i;
    logic                 r_ready_o;
    logic [DataWidth-1:0] dma_data_o;
    logic                 dma_valid_o;
    logic                 dma_ready_i;
    logic                 dma_last_o;
    logic [1:0]           dma_type_o;
    logic                 unrec_error_o;
    fetch_state_e         fsm_state;

    modport master (
        input  fetch_valid_i, fetch_addr_i, fetch_type_i,
        output fetch_ready_o,
        output ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o, ar_valid_o,
        input  ar_ready_i,
        input  r_data_i, r_resp_i, r_last_i, r_valid_i,
        output r_ready_o,
        output dma_data_o, dma_valid_o, dma_last_o, dma_type_o,
        input  dma_ready_i,
        output unrec_error_o, fsm_state
    );

    modport slave (
        output fetch_valid_i, fetch_addr_i, fetch_type_i,
        input  fetch_ready_o,
        input  ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o, ar_valid_o,
        output ar_ready_i,
        output r_data_i, r_resp_i, r_last_i, r_valid_i,
        input  r_ready_o,
        input  dma_data_o, dma_valid_o, dma_last_o, dma_type_o,
        output dma_ready_i,
        input  unrec_error_o, fsm_state
    );
endinterface

// File: rtl/new_usb_descriptor_fetch.sv
// new_usb_descriptor_fetch
// Fetches one OHCI descriptor per request with a single AXI INCR read burst
// and streams the returned beats to the descriptor unpacker.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : fetch request, AXI AR/R and unpacker stream (master view)
// R beats pass straight through to the unpacker in DATA; error responses
// and RLAST/beat-count disagreements raise unrec_error_o one cycle later.
// AxiDataWidth must be 32, 64 or 128; AxiAddrWidth must be >= 32.
module new_usb_descriptor_fetch
    import new_usb_descriptor_fetch_pkg::*;
#(
    parameter int                    AxiAddrWidth = 32,
    parameter int                    AxiDataWidth = 32,
    parameter int                    AxiIdWidth   = 4,
    parameter logic [AxiIdWidth-1:0] AxiId        = '0
) (
    input logic                       clk_i,
    input logic                       rst_i,
    new_usb_descriptor_fetch_if.master bus
);

    // ARLEN for 16-byte (ED/GTD) and 32-byte (ITD) descriptors.
    localparam logic [7:0] LenShort = 8'(fetch_beats(FETCH_ED, AxiDataWidth) - 1);
    localparam logic [7:0] LenItd   = 8'(fetch_beats(FETCH_ITD, AxiDataWidth) - 1);
    localparam logic [2:0] ArSize   = 3'($clog2(AxiDataWidth / 8));

    fetch_state_e            state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [1:0]              type_q, type_d;
    logic [BeatCntWidth-1:0] beat_q, beat_d;
    logic                    err_q, err_d;

    logic resp_ok;
    logic at_last;
    logic r_ready;
    logic beat_hs;

    assign resp_ok = (bus.r_resp_i == AxiRespOkay);
    assign at_last = (beat_q == len_q[BeatCntWidth-1:0]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            type_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            type_q  <= type_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        type_d  = type_q;
        beat_d  = beat_q;
        err_d   = 1'b0;
        r_ready = 1'b0;

        // An error beat is swallowed here, so it must not wait on the
        // unpacker; DRAIN always sinks beats.
        case (state_q)
            DATA:    r_ready = bus.dma_ready_i | (bus.r_valid_i & ~resp_ok);
            DRAIN:   r_ready = 1'b1;
            default: r_ready = 1'b0;
        endcase
        beat_hs = bus.r_valid_i & r_ready;

        case (state_q)
            IDLE: begin
                if (bus.fetch_valid_i) begin
                    if (fetch_type_e'(bus.fetch_type_i) == FETCH_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = {bus.fetch_addr_i, 4'h0};
                        type_d = bus.fetch_type_i;
                        if (fetch_type_e'(bus.fetch_type_i) == FETCH_ITD) begin
                            addr_d[4] = 1'b0;  // ITDs are 32-byte aligned
                            len_d     = LenItd;
                        end else begin
                            len_d = LenShort;
                        end
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (bus.ar_ready_i) begin
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat_hs) begin
                    if (!resp_ok) begin
                        err_d = 1'b1;
                        if (bus.r_last_i) state_d = IDLE;
                        else              state_d = DRAIN;
                    end else if (bus.r_last_i) begin
                        // Early RLAST is still a clean end of burst, but an error.
                        err_d   = ~at_last;
                        state_d = IDLE;
                    end else if (at_last) begin
                        // Slave sends more beats than asked for: sink the rest.
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (beat_hs && bus.r_last_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.fetch_ready_o = (state_q == IDLE);
    assign bus.ar_addr_o     = AxiAddrWidth'(addr_q);
    assign bus.ar_len_o      = len_q;
    assign bus.ar_size_o     = ArSize;
    assign bus.ar_burst_o    = AxiBurstIncr;
    assign bus.ar_id_o       = AxiId;
    assign bus.ar_valid_o    = (state_q == ADDR);
    assign bus.r_ready_o     = r_ready;
    assign bus.dma_data_o    = bus.r_data_i;
    assign bus.dma_valid_o   = (state_q == DATA) & bus.r_valid_i & resp_ok;
    assign bus.dma_last_o    = (state_q == DATA) & (at_last | (bus.r_valid_i & bus.r_last_i));
    assign bus.dma_type_o    = type_q;
    assign bus.unrec_error_o = err_q;
    assign bus.fsm_state     = state_q;

endmodule

// File: tb/tb_new_usb_descriptor_fetch.sv
// tb_new_usb_descriptor_fetch
// Drives three instances (32/64/128-bit data) of the descriptor fetch
// stage from one shared stimulus set; only the instance picked by sel
// sees fetch/R valids, and its outputs are muxed onto o_* for checking.
module tb_new_usb_descriptor_fetch;
    import new_usb_descriptor_fetch_pkg::*;

    localparam int ExpW = 129;  // {last, data[127:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic [1:0]   sel = 2'd0;
    logic         fetch_valid = 1'b0;
    logic [27:0]  fetch_addr = '0;
    logic [1:0]   fetch_type = '0;
    logic         ar_ready = 1'b0;
    logic [127:0] r_data = '0;
    logic [1:0]   r_resp = '0;
    logic         r_last = 1'b0;
    logic         r_valid = 1'b0;
    logic         dma_ready = 1'b1;

    int checks = 0;
    int failures = 0;
    int err_pulses = 0;
    int dma_hs = 0;
    logic [1:0] exp_type = '0;
    logic [ExpW-1:0] exp_q[$];

    new_usb_descriptor_fetch_if #(.AddrWidth(32), .DataWidth(32),  .IdWidth(4)) b32 ();
    new_usb_descriptor_fetch_if #(.AddrWidth(32), .DataWidth(64),  .IdWidth(4)) b64 ();
    new_usb_descriptor_fetch_if #(.AddrWidth(32), .DataWidth(128), .IdWidth(4)) b128 ();

    new_usb_descriptor_fetch #(.AxiAddrWidth(32), .AxiDataWidth(32),  .AxiIdWidth(4), .AxiId(4'h0))
        u32 (.clk_i(clk), .rst_i(rst), .bus(b32));
    new_usb_descriptor_fetch #(.AxiAddrWidth(32), .AxiDataWidth(64),  .AxiIdWidth(4), .AxiId(4'h5))
        u64 (.clk_i(clk), .rst_i(rst), .bus(b64));
    new_usb_descriptor_fetch #(.AxiAddrWidth(32), .AxiDataWidth(128), .AxiIdWidth(4), .AxiId(4'ha))
        u128 (.clk_i(clk), .rst_i(rst), .bus(b128));

    assign b32.fetch_valid_i = fetch_valid & (sel == 2'd0);
    assign b32.fetch_addr_i  = fetch_addr;
    assign b32.fetch_type_i  = fetch_type;
    assign b32.ar_ready_i    = ar_ready;
    assign b32.r_data_i      = r_data[31:0];
    assign b32.r_resp_i      = r_resp;
    assign b32.r_last_i      = r_last;
    assign b32.r_valid_i     = r_valid & (sel == 2'd0);
    assign b32.dma_ready_i   = dma_ready;

    assign b64.fetch_valid_i = fetch_valid & (sel == 2'd1);
    assign b64.fetch_addr_i  = fetch_addr;
    assign b64.fetch_type_i  = fetch_type;
    assign b64.ar_ready_i    = ar_ready;
    assign b64.r_data_i      = r_data[63:0];
    assign b64.r_resp_i      = r_resp;
    assign b64.r_last_i      = r_last;
    assign b64.r_valid_i     = r_valid & (sel == 2'd1);
    assign b64.dma_ready_i   = dma_ready;

    assign b128.fetch_valid_i = fetch_valid & (sel == 2'd2);
    assign b128.fetch_addr_i  = fetch_addr;
    assign b128.fetch_type_i  = fetch_type;
    assign b128.ar_ready_i    = ar_ready;
    assign b128.r_data_i      = r_data;
    assign b128.r_resp_i      = r_resp;
    assign b128.r_last_i      = r_last;
    assign b128.r_valid_i     = r_valid & (sel == 2'd2);
    assign b128.dma_ready_i   = dma_ready;

    // ---------------- observed outputs of the selected instance ----------------
    logic         o_fetch_ready, o_ar_valid, o_r_ready, o_dma_valid, o_dma_last, o_unrec;
    logic [31:0]  o_ar_addr;
    logic [7:0]   o_ar_len;
    logic [2:0]   o_ar_size;
    logic [1:0]   o_ar_burst, o_dma_type;
    logic [3:0]   o_ar_id;
    logic [127:0] o_dma_data;
    fetch_state_e o_state;

    always_comb begin
        o_fetch_ready = b32.fetch_ready_o;  o_ar_valid = b32.ar_valid_o;
        o_r_ready     = b32.r_ready_o;      o_dma_valid = b32.dma_valid_o;
        o_dma_last    = b32.dma_last_o;     o_unrec = b32.unrec_error_o;
        o_ar_addr     = b32.ar_addr_o;      o_ar_len = b32.ar_len_o;
        o_ar_size     = b32.ar_size_o;      o_ar_burst = b32.ar_burst_o;
        o_ar_id       = b32.ar_id_o;        o_dma_type = b32.dma_type_o;
        o_dma_data    = 128'(b32.dma_data_o);
        o_state       = b32.fsm_state;
        if (sel == 2'd1) begin
            o_fetch_ready = b64.fetch_ready_o;  o_ar_valid = b64.ar_valid_o;
            o_r_ready     = b64.r_ready_o;      o_dma_valid = b64.dma_valid_o;
            o_dma_last    = b64.dma_last_o;     o_unrec = b64.unrec_error_o;
            o_ar_addr     = b64.ar_addr_o;      o_ar_len = b64.ar_len_o;
            o_ar_size     = b64.ar_size_o;      o_ar_burst = b64.ar_burst_o;
            o_ar_id       = b64.ar_id_o;        o_dma_type = b64.dma_type_o;
            o_dma_data    = 128'(b64.dma_data_o);
            o_state       = b64.fsm_state;
        end else if (sel == 2'd2) begin
            o_fetch_ready = b128.fetch_ready_o; o_ar_valid = b128.ar_valid_o;
            o_r_ready     = b128.r_ready_o;     o_dma_valid = b128.dma_valid_o;
            o_dma_last    = b128.dma_last_o;    o_unrec = b128.unrec_error_o;
            o_ar_addr     = b128.ar_addr_o;     o_ar_len = b128.ar_len_o;
            o_ar_size     = b128.ar_size_o;     o_ar_burst = b128.ar_burst_o;
            o_ar_id       = b128.ar_id_o;       o_dma_type = b128.dma_type_o;
            o_dma_data    = b128.dma_data_o;
            o_state       = b128.fsm_state;
        end
    end

    // ---------------- scoreboard ----------------
    // Every beat presented to the unpacker must match the queue head and stay
    // stable until taken; it is popped only when dma_ready accepts it.
    always @(negedge clk) begin
        logic [ExpW-1:0] e;
        if (!rst && o_dma_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat sel=%0d got data=%h last=%b exp=none", sel, o_dma_data, o_dma_last);
            end else begin
                e = exp_q[0];
                if (o_dma_data !== e[127:0] || o_dma_last !== e[128]) begin
                    failures++;
                    $display("FAIL beat sel=%0d got data=%h last=%b exp data=%h last=%b",
                             sel, o_dma_data, o_dma_last, e[127:0], e[128]);
                end
                checks++;
                if (o_dma_type !== exp_type) begin
                    failures++;
                    $display("FAIL dma_type got=%0d exp=%0d", o_dma_type, exp_type);
                end
                if (dma_ready) begin
                    void'(exp_q.pop_front());
                    dma_hs++;
                end
            end
        end
        if (!rst && o_unrec) err_pulses++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [27:0] a, input logic [1:0] t);
        fetch_valid = 1'b1;
        fetch_addr  = a;
        fetch_type  = t;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic ar_grant();
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
    endtask

    function automatic logic [127:0] rand_beat(input logic [1:0] s);
        logic [127:0] d;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (s == 2'd0) d[127:32] = '0;
        else if (s == 2'd1) d[127:64] = '0;
        return d;
    endfunction

    // Presents one R beat and holds it until r_ready takes it (bounded).
    task automatic send_beat(input logic [127:0] d, input logic [1:0] resp, input logic last);
        logic done;
        done    = 1'b0;
        r_valid = 1'b1;
        r_data  = d;
        r_resp  = resp;
        r_last  = last;
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge clk);
            done = o_r_ready;
            tick();
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_resp  = 2'b00;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL r_handshake_timeout sel=%0d got=no_rready exp=rready", sel);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if ({o_fetch_ready, o_ar_valid, o_r_ready, o_dma_valid, o_dma_last, o_unrec} !== 6'b100000) begin
                failures++;
                $display("FAIL reset_ctrl sel=%0d got=%b exp=100000", s,
                         {o_fetch_ready, o_ar_valid, o_r_ready, o_dma_valid, o_dma_last, o_unrec});
            end
            checks++;
            if (o_ar_addr !== 32'h0 || o_ar_len !== 8'h0 || o_dma_type !== 2'd0 || o_state !== IDLE) begin
                failures++;
                $display("FAIL reset_regs sel=%0d got addr=%h len=%0d type=%0d st=%0d exp=0",
                         s, o_ar_addr, o_ar_len, o_dma_type, o_state);
            end
        end
        sel = 2'd0;
        rst = 1'b0;
        tick();
        // R traffic while idle must be ignored.
        r_valid = 1'b1;
        r_data  = 128'h1234;
        @(negedge clk);
        checks++;
        if (o_r_ready !== 1'b0 || o_dma_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_r_ignored got rready=%b dvalid=%b exp=0 0", o_r_ready, o_dma_valid);
        end
        r_valid = 1'b0;
        tick();
    endtask

    task automatic test_ed_w32();
        logic [127:0] d;
        int e0;
        sel = 2'd0; exp_type = FETCH_ED; e0 = err_pulses;
        @(negedge clk);
        checks++;
        if (o_fetch_ready !== 1'b1) begin
            failures++; $display("FAIL ed_fetch_ready_idle got=%b exp=1", o_fetch_ready);
        end
        issue(28'h0001234, FETCH_ED);
        @(negedge clk);
        checks++;
        if (o_ar_valid !== 1'b1 || o_fetch_ready !== 1'b0) begin
            failures++; $display("FAIL ed_arvalid got arvalid=%b fready=%b exp=1 0", o_ar_valid, o_fetch_ready);
        end
        checks++;
        if (o_ar_addr !== 32'h00012340 || o_ar_len !== 8'd3 || o_ar_size !== 3'd2 ||
            o_ar_burst !== 2'd1 || o_ar_id !== 4'h0) begin
            failures++;
            $display("FAIL ed_ar got addr=%h len=%0d size=%0d burst=%0d id=%0d exp=00012340 3 2 1 0",
                     o_ar_addr, o_ar_len, o_ar_size, o_ar_burst, o_ar_id);
        end
        ar_grant();
        for (int i = 0; i < 4; i++) begin
            d = rand_beat(sel);
            exp_q.push_back({i == 3, d});
            send_beat(d, 2'b00, i == 3);
        end
        @(negedge clk);
        checks++;
        if (o_fetch_ready !== 1'b1 || o_state !== IDLE || exp_q.size() != 0 || err_pulses != e0) begin
            failures++;
            $display("FAIL ed_end got fready=%b st=%0d pending=%0d errs=%0d exp=1 0 0 0",
                     o_fetch_ready, o_state, exp_q.size(), err_pulses - e0);
        end
    endtask

    task automatic test_itd_w64_backpressure();
        logic [127:0] d;
        int e0, h0;
        sel = 2'd1; exp_type = FETCH_ITD; e0 = err_pulses; h0 = dma_hs;
        issue(28'h0000011, FETCH_ITD);
        @(negedge clk);
        checks++;
        if (o_ar_valid !== 1'b1 || o_ar_addr !== 32'h00000100 || o_ar_len !== 8'd3 ||
            o_ar_size !== 3'd3 || o_ar_id !== 4'h5) begin
            failures++;
            $display("FAIL itd_ar got v=%b addr=%h len=%0d size=%0d id=%0d exp=1 00000100 3 3 5",
                     o_ar_valid, o_ar_addr, o_ar_len, o_ar_size, o_ar_id);
        end
        ar_grant();
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    dma_ready = (i % 2 == 0);
                    tick();
                end
                dma_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    d = rand_beat(sel);
                    exp_q.push_back({i == 3, d});
                    send_beat(d, 2'b00, i == 3);
                end
            end
        join
        @(negedge clk);
        checks++;
        if (dma_hs - h0 != 4 || exp_q.size() != 0 || o_state !== IDLE || err_pulses != e0) begin
            failures++;
            $display("FAIL itd_end got hs=%0d pending=%0d st=%0d errs=%0d exp=4 0 0 0",
                     dma_hs - h0, exp_q.size(), o_state, err_pulses - e0);
        end
    endtask

    task automatic test_gtd_w128_ar_stall();
        logic [127:0] d;
        sel = 2'd2; exp_type = FETCH_GTD;
        issue(28'hABCDEF1, FETCH_GTD);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (o_ar_valid !== 1'b1 || o_ar_addr !== 32'hABCDEF10) begin
                failures++;
                $display("FAIL gtd_ar_hold cyc=%0d got v=%b addr=%h exp=1 abcdef10", i, o_ar_valid, o_ar_addr);
            end
        end
        checks++;
        if (o_ar_len !== 8'd0 || o_ar_size !== 3'd4 || o_ar_id !== 4'ha) begin
            failures++;
            $display("FAIL gtd_ar got len=%0d size=%0d id=%0d exp=0 4 10", o_ar_len, o_ar_size, o_ar_id);
        end
        ar_grant();
        d = rand_beat(sel);
        exp_q.push_back({1'b1, d});
        send_beat(d, 2'b00, 1'b1);
        @(negedge clk);
        checks++;
        if (o_fetch_ready !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL gtd_end got fready=%b pending=%0d exp=1 0", o_fetch_ready, exp_q.size());
        end
    endtask

    task automatic test_slverr();
        logic [127:0] d;
        int e0;
        sel = 2'd0; exp_type = FETCH_ED; e0 = err_pulses;
        issue(28'h0000300, FETCH_ED);
        @(negedge clk);
        ar_grant();
        d = rand_beat(sel);
        exp_q.push_back({1'b0, d});
        send_beat(d, 2'b00, 1'b0);
        send_beat(rand_beat(sel), 2'b10, 1'b0);
        @(negedge clk);
        checks++;
        if (o_state !== DRAIN || o_unrec !== 1'b1) begin
            failures++; $display("FAIL slverr_drain got st=%0d err=%b exp=3 1", o_state, o_unrec);
        end
        send_beat(rand_beat(sel), 2'b00, 1'b0);
        send_beat(rand_beat(sel), 2'b00, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (err_pulses - e0 != 1 || o_state !== IDLE || exp_q.size() != 0) begin
            failures++;
            $display("FAIL slverr_end got errs=%0d st=%0d pending=%0d exp=1 0 0",
                     err_pulses - e0, o_state, exp_q.size());
        end
    endtask

    task automatic test_early_last();
        logic [127:0] d;
        int e0;
        sel = 2'd0; exp_type = FETCH_ED; e0 = err_pulses;
        issue(28'h0000400, FETCH_ED);
        @(negedge clk);
        ar_grant();
        d = rand_beat(sel);
        exp_q.push_back({1'b0, d});
        send_beat(d, 2'b00, 1'b0);
        d = rand_beat(sel);
        exp_q.push_back({1'b1, d});
        send_beat(d, 2'b00, 1'b1);
        @(negedge clk);
        checks++;
        if (o_state !== IDLE || o_unrec !== 1'b1 || o_fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL early_last got st=%0d err=%b fready=%b exp=0 1 1", o_state, o_unrec, o_fetch_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (err_pulses - e0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL early_last_end got errs=%0d pending=%0d exp=1 0", err_pulses - e0, exp_q.size());
        end
    endtask

    task automatic test_missing_last();
        logic [127:0] d;
        int e0;
        sel = 2'd0; exp_type = FETCH_ED; e0 = err_pulses;
        issue(28'h0000500, FETCH_ED);
        @(negedge clk);
        ar_grant();
        for (int i = 0; i < 4; i++) begin
            d = rand_beat(sel);
            exp_q.push_back({i == 3, d});
            send_beat(d, 2'b00, 1'b0);
        end
        @(negedge clk);
        checks++;
        if (o_state !== DRAIN || o_unrec !== 1'b1) begin
            failures++; $display("FAIL missing_last_drain got st=%0d err=%b exp=3 1", o_state, o_unrec);
        end
        // DRAIN must sink beats even with the unpacker stalled.
        dma_ready = 1'b0;
        send_beat(rand_beat(sel), 2'b00, 1'b0);
        send_beat(rand_beat(sel), 2'b00, 1'b1);
        dma_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (err_pulses - e0 != 1 || o_state !== IDLE || exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_last_end got errs=%0d st=%0d pending=%0d exp=1 0 0",
                     err_pulses - e0, o_state, exp_q.size());
        end
    endtask

    task automatic test_reserved_type();
        int e0;
        sel = 2'd0; e0 = err_pulses;
        issue(28'h0000040, 2'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (o_ar_valid !== 1'b0 || o_fetch_ready !== 1'b1 || o_unrec !== (i == 0)) begin
                failures++;
                $display("FAIL reserved cyc=%0d got arv=%b fready=%b err=%b exp=0 1 %b",
                         i, o_ar_valid, o_fetch_ready, o_unrec, i == 0);
            end
        end
        checks++;
        if (err_pulses - e0 != 1) begin
            failures++; $display("FAIL reserved_pulses got=%0d exp=1", err_pulses - e0);
        end
        tick();
    endtask

    task automatic test_reset_mid_data();
        logic [127:0] d;
        sel = 2'd0; exp_type = FETCH_GTD;
        issue(28'h0000600, FETCH_GTD);
        @(negedge clk);
        ar_grant();
        d = rand_beat(sel);
        exp_q.push_back({1'b0, d});
        send_beat(d, 2'b00, 1'b0);
        r_valid = 1'b1;
        r_data  = rand_beat(sel);
        rst     = 1'b1;
        #1;
        checks++;
        if ({o_fetch_ready, o_ar_valid, o_r_ready, o_dma_valid, o_dma_last, o_unrec} !== 6'b100000 ||
            o_state !== IDLE || o_ar_addr !== 32'h0 || o_ar_len !== 8'h0 || o_dma_type !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_data got ctrl=%b st=%0d addr=%h len=%0d type=%0d exp=100000 0 0 0 0",
                     {o_fetch_ready, o_ar_valid, o_r_ready, o_dma_valid, o_dma_last, o_unrec},
                     o_state, o_ar_addr, o_ar_len, o_dma_type);
        end
        r_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (exp_q.size() != 0 || o_fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_data_end got pending=%0d fready=%b exp=0 1", exp_q.size(), o_fetch_ready);
        end
    endtask

    initial begin
        test_reset();
        test_ed_w32();
        test_itd_w64_backpressure();
        test_gtd_w128_ar_stall();
        test_slverr();
        test_early_last();
        test_missing_last();
        test_reserved_type();
        test_reset_mid_data();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/new_usb_descriptor_fetch.md
Name: new_usb_descriptor_fetch

Overview:
- DMA read stage directly upstream of the OHCI descriptor unpacker.
- Accepts one descriptor fetch request (address + descriptor kind) from the list service.
- Issues a single AXI4 INCR read burst of exactly one descriptor, then streams the returned beats to the unpacker's dma_data/valid/ready input with backpressure.
- Flags AXI errors as an OHCI unrecoverable-error pulse.

Parameters:
- AxiAddrWidth, 32, DMA address width; must be >= 32, upper bits driven 0.
- AxiDataWidth, 32, R data width; legal values 32, 64, 128 only.
- AxiIdWidth, 4, AR/R ID width.
- AxiId, '0, constant ARID presented on every read.

Ports:
- clk_i  in  1  SoC clock.
- rst_i  in  1  Asynchronous, active-high reset.
- fetch_valid_i  in  1  Fetch request valid.
- fetch_ready_o  out  1  Fetch request accepted when high together with fetch_valid_i.
- fetch_addr_i  in  28  Descriptor address bits [31:4] (16-byte aligned).
- fetch_type_i  in  2  fetch_type_e: FETCH_ED=0, FETCH_GTD=1, FETCH_ITD=2; 3 is reserved.
- ar_addr_o  out  AxiAddrWidth  AXI ARADDR.
- ar_len_o  out  8  AXI ARLEN.
- ar_size_o  out  3  AXI ARSIZE = log2(AxiDataWidth/8).
- ar_burst_o  out  2  AXI ARBURST, constant INCR (2'b01).
- ar_id_o  out  AxiIdWidth  AXI ARID, equals AxiId.
- ar_valid_o  out  1  AXI ARVALID.
- ar_ready_i  in  1  AXI ARREADY.
- r_data_i  in  AxiDataWidth  AXI RDATA.
- r_resp_i  in  2  AXI RRESP.
- r_last_i  in  1  AXI RLAST.
- r_valid_i  in  1  AXI RVALID.
- r_ready_o  out  1  AXI RREADY.
- dma_data_o  out  AxiDataWidth  Descriptor beat to the unpacker.
- dma_valid_o  out  1  Beat valid.
- dma_ready_i  in  1  Unpacker ready.
- dma_last_o  out  1  Final beat of the descriptor.
- dma_type_o  out  2  fetch_type_e of the descriptor in flight.
- unrec_error_o  out  1  One-cycle pulse on bus or protocol error.

Behaviour:
- FSM states: IDLE, ADDR, DATA, DRAIN. Reset state is IDLE.
- Reset values: ar_valid_o=0, r_ready_o=0, dma_valid_o=0, dma_last_o=0, unrec_error_o=0, fetch_ready_o=1, all address/len/type registers 0.
- IDLE: fetch_ready_o=1.
  - On fetch_valid_i, latch address/type/len. Address = {fetch_addr_i, 4'h0}; for FETCH_ITD, bit 4 is forced 0 (32-byte aligned).
  - Go to ADDR; ar_valid_o rises the cycle after acceptance.
  - FETCH type 3: accepted, no AR issued, unrec_error_o pulses the next cycle, stays IDLE.
- Beat count N = descriptor bytes / (AxiDataWidth/8); ED and GTD are 16 bytes, ITD is 32 bytes.
  - ED/GTD: N = 4, 2, 1 for widths 32, 64, 128.
  - ITD: N = 8, 4, 2.
  - ar_len_o = N-1.
- ADDR: ar_valid_o held high with stable payload until ar_ready_i; then go to DATA with beat counter cleared. fetch_ready_o=0 in all states except IDLE.
- DATA: zero-latency pass-through.
  - dma_data_o = r_data_i.
  - dma_valid_o = r_valid_i.
  - r_ready_o = dma_ready_i.
  - dma_last_o = (beat counter == N-1).
  - Beat counter increments on r_valid_i & r_ready_o.
- Beat with r_resp_i != OKAY (SLVERR/DECERR):
  - dma_valid_o suppressed for that beat, which is consumed internally.
  - unrec_error_o pulses the next cycle.
  - Go to DRAIN unless r_last_i is set, in which case go to IDLE.
- Protocol mismatch also pulses unrec_error_o:
  - r_last_i on a beat with counter != N-1: that beat is forwarded, dma_last_o=1 forced, then IDLE.
  - Counter reaching N-1 without r_last_i: go to DRAIN.
- Otherwise the last handshaked beat with r_last_i returns the FSM to IDLE. A new request can be accepted on the following cycle, giving one idle cycle between descriptors.
- DRAIN: r_ready_o=1, dma_valid_o=0, discard beats until r_last_i is handshaked, then IDLE.
- Only one outstanding read. r_valid_i in IDLE or ADDR is ignored (r_ready_o=0).
- rst_i asserted mid-burst returns the FSM to IDLE asynchronously; in-flight beats are not tracked. The system resets the AXI fabric together with this block.

Decomposition:
- new_usb_ohci_pkg gains:
  - fetch_type_e (2-bit enum).
  - Constants EdBytes=16, GtdBytes=16, ItdBytes=32.
  - Function fetch_beats(type, data_width) returning N.
- Beat counter width is $clog2(8).
- No sub-module; the FSM, counter and pass-through form one module.

Test Plan:
- W=32, FETCH_ED, addr 28'h0001234: ARADDR=32'h00012340, ARLEN=3, ARSIZE=2, ARBURST=1; 4 OKAY beats forwarded in order, dma_last_o only on beat 3; fetch_ready_o returns 1 the cycle after RLAST.
- W=64, FETCH_ITD, addr 28'h0000011: ARADDR=32'h00000100 (bit 4 cleared), ARLEN=3; dma_ready_i toggled 1-0-1-0 during R: every beat held stable and delivered exactly once.
- W=128, FETCH_GTD: ARLEN=0, single beat carries dma_last_o=1; ar_ready_i held low 5 cycles: ARVALID stays high with constant ARADDR.
- W=32 ED, beat 1 RRESP=SLVERR: beat 0 forwarded; beats 1-3 not forwarded; one unrec_error_o pulse; back in IDLE after RLAST.
- W=32 ED, RLAST on beat 1: beat 1 forwarded with dma_last_o=1, unrec_error_o pulse, IDLE. Second run with no RLAST at beat 3 and RLAST on beat 5: beats 4-5 discarded in DRAIN, one error pulse.
- fetch_type_i=3: no ARVALID ever, unrec_error_o pulses once. Separately, rst_i during DATA: all outputs at reset values immediately, fetch_ready_o=1.
